// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed display path: code width, message
// contents and the writer's commit FSM states.
package display_pkg;

  localparam int CHAR_W          = 4;
  localparam int MSG_LEN_DEFAULT = 16;
  localparam int MSG_IDX_W       = $clog2(MSG_LEN_DEFAULT);

  localparam logic [CHAR_W-1:0] MSG [MSG_LEN_DEFAULT] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
    4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
  };

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsm_state_e;

  // Message lookup with modulo wrap (message length is a power of two).
  function automatic logic [CHAR_W-1:0] msg_char(input int unsigned idx);
    logic [MSG_IDX_W-1:0] i;
    i = MSG_IDX_W'(idx);
    return MSG[i];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2;

  assign s2 = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], btn_in};
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    pulse_d    = deb_q & ~deb_prev_q;
    // The level only flips after s2 has disagreed for DEB_CYCLES straight cycles.
    if (s2 != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = s2;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/msg_scroll_writer.sv
// Scrolling-message writer: advances a 4-character window over the message on
// button or auto tick, committing only on the scanner's frame boundary.
module msg_scroll_writer
  import display_pkg::*;
#(
  parameter int MSG_LEN    = MSG_LEN_DEFAULT,
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step_btn,
  input  logic                       auto_mode,
  input  logic                       frame_done,
  output logic [CHAR_W-1:0]          char3,
  output logic [CHAR_W-1:0]          char2,
  output logic [CHAR_W-1:0]          char1,
  output logic [CHAR_W-1:0]          char0,
  output logic [$clog2(MSG_LEN)-1:0] ptr,
  output logic                       pending
);

  localparam int PTR_W  = $clog2(MSG_LEN);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef logic [3:0][CHAR_W-1:0] window_t;

  // Element 3 is the leftmost digit, so window[3] = MSG[p].
  function automatic window_t window_at(input logic [PTR_W-1:0] p);
    window_t          w;
    logic [PTR_W-1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx      = p + PTR_W'(k);
      w[3 - k] = msg_char(32'(idx));
    end
    return w;
  endfunction

  logic              step_req;
  logic              tick;
  logic              step_ev;
  logic [TICK_W-1:0] tcnt_q, tcnt_d;
  fsm_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  window_t           win_q, win_d;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (step_btn),
    .pulse_out(step_req)
  );

  assign tick    = auto_mode && (tcnt_q == TICK_LAST);
  assign step_ev = step_req | tick;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    tcnt_d = '0;
    if (auto_mode && !tick) tcnt_d = tcnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    if (state_q == IDLE) begin
      if (step_ev) state_d = WAIT;
    end else if (frame_done) begin
      // A fresh event arriving with the commit re-arms instead of being lost.
      ptr_d   = ptr_q + 1'b1;
      win_d   = window_at(ptr_d);
      state_d = step_ev ? WAIT : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= window_at('0);
    end else begin
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign char3   = win_q[3];
  assign char2   = win_q[2];
  assign char1   = win_q[1];
  assign char0   = win_q[0];
  assign ptr     = ptr_q;
  assign pending = (state_q == WAIT);

endmodule
